crypto1_search_engine: RTL and testbench

- Parametrised successor to the single Crypto1 core.
- Buffers a list of odd-half subkeys from one subkey generator, then streams even-half subkeys from a second generator.
- For every even/odd pair, it builds a 48-bit LFSR state and runs the Crypto1 cipher forward, comparing the filter output against a captured keystream.
- It reports matching keys and sits between two GenSubkey instances and the top-level key collector.

---
 rtl/crypto1_search_engine.sv | 248 ++++++++++++++++++++++++
 tb/tb_crypto1_search_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto1_search_engine.sv
// crypto1_search_engine
//
// Brute-force key search core for the Crypto1 cipher. A list of odd-half
// subkeys is buffered from one subkey generator. Even-half subkeys are then
// streamed from a second generator. For every (even, odd) pair the 48-bit LFSR
// is run forward, and its filter output is compared bit by bit against a
// captured keystream. A pair that reproduces the whole keystream is reported
// as a key.
//
// Optional feature: define CRYPTO1_MULTI_MATCH_EN to keep searching after a
// match. Without it, the first match ends the search.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start             1-cycle pulse, begins a search (ignored unless idle)
//   i_bitstream         keystream, bit k = k-th cipher output, sampled on start
//   i_odd_*/o_odd_ready odd subkey stream (valid/ready, last marks final word)
//   i_even_*/o_even_ready even subkey stream (valid/ready, last marks final word)
//   o_key, o_key_valid  matching key (key[2i]=even[i], key[2i+1]=odd[i]) + pulse
//   o_busy              high from start until the search finishes
//   o_done              sticky end-of-search flag, cleared by the next start
//   o_found             sticky, at least one match in this search
//   o_overflow          sticky, odd subkeys were dropped because the buffer was full
module crypto1_search_engine #(
    parameter int KS_BITS   = 48,
    parameter int ODD_DEPTH = 256,
    parameter int SUBKEY_W  = 24
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [KS_BITS-1:0]    i_bitstream,
    input  logic                  i_odd_valid,
    input  logic [SUBKEY_W-1:0]   i_odd_data,
    input  logic                  i_odd_last,
    output logic                  o_odd_ready,
    input  logic                  i_even_valid,
    input  logic [SUBKEY_W-1:0]   i_even_data,
    input  logic                  i_even_last,
    output logic                  o_even_ready,
    output logic [2*SUBKEY_W-1:0] o_key,
    output logic                  o_key_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_found,
    output logic                  o_overflow
);

    localparam int AW = $clog2(ODD_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(KS_BITS);
    localparam logic [SUBKEY_W-1:0] POLY_ODD  = SUBKEY_W'(24'h29CE5C);
    localparam logic [SUBKEY_W-1:0] POLY_EVEN = SUBKEY_W'(24'h870804);

    if (SUBKEY_W != 24) begin : g_chk_subkey_w
        $error("crypto1_search_engine: SUBKEY_W must be 24");
    end
    if (KS_BITS < 8 || KS_BITS > 64) begin : g_chk_ks_bits
        $error("crypto1_search_engine: KS_BITS must be in 8..64");
    end
    if (ODD_DEPTH < 2 || (ODD_DEPTH & (ODD_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("crypto1_search_engine: ODD_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_ODD, S_WAIT_EVEN, S_LOAD_CAND, S_RUN, S_NEXT, S_FINISH
    } state_t;

    state_t                r_state, w_next_state;
    logic [KS_BITS-1:0]    r_ks;
    logic [SUBKEY_W-1:0]   r_buf [ODD_DEPTH];
    logic [CW-1:0]         r_wr_cnt;
    logic [AW-1:0]         r_rd_idx;
    logic [SUBKEY_W-1:0]   r_even_in;
    logic                  r_even_last;
    logic [SUBKEY_W-1:0]   r_odd;
    logic [SUBKEY_W-1:0]   r_even;
    logic [BW-1:0]         r_bit_idx;
    logic [2*SUBKEY_W-1:0] r_key;
    logic                  r_key_valid, r_busy, r_done, r_found, r_overflow;

    logic                  w_odd_acc, w_even_acc, w_full, w_fb, w_mismatch;
    logic                  w_last_bit, w_more;
    logic [SUBKEY_W-1:0]   w_cand_odd, w_even_shift;
    logic [2*SUBKEY_W-1:0] w_key;

    // Crapto1 filter: five 4-bit lookups over odd-register bits 0..19 form a
    // 5-bit index into the final 32-entry table.
    function automatic logic filter20(input logic [SUBKEY_W-1:0] x);
        logic [19:0] a, b, c, d, e;
        logic [4:0]  f;
        logic [31:0] g;
        a = 20'hF22C0 >> x[3:0];
        b = 20'h6C9C0 >> x[7:4];
        c = 20'h3C8B0 >> x[11:8];
        d = 20'h1E458 >> x[15:12];
        e = 20'h0D938 >> x[19:16];
        f = {a[4], b[3], c[2], d[1], e[0]};
        g = 32'hEC57E80A >> f;
        return g[0];
    endfunction

    assign w_odd_acc    = i_odd_valid && (r_state == S_LOAD_ODD);
    assign w_even_acc   = i_even_valid && (r_state == S_WAIT_EVEN);
    assign w_full       = (r_wr_cnt == CW'(ODD_DEPTH));
    assign w_fb         = ^((r_odd & POLY_ODD) ^ (r_even & POLY_EVEN));
    assign w_even_shift = {r_even[SUBKEY_W-2:0], w_fb};
    assign w_mismatch   = (filter20(r_odd) != r_ks[r_bit_idx]);
    assign w_last_bit   = (r_bit_idx == BW'(KS_BITS - 1));
    // wr_cnt saturates at ODD_DEPTH, so it already equals min(wr_cnt, depth)
    assign w_more       = (({1'b0, r_rd_idx} + CW'(1)) < r_wr_cnt);
    // The buffer entry under test still holds the candidate's initial odd half
    assign w_cand_odd   = r_buf[r_rd_idx];

    always_comb begin
        w_key = '0;
        for (int i = 0; i < SUBKEY_W; i++) begin
            w_key[2*i]   = r_even_in[i];
            w_key[2*i+1] = w_cand_odd[i];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        o_odd_ready  = 1'b0;
        o_even_ready = 1'b0;
        case (r_state)
            S_IDLE:      if (i_start) w_next_state = S_LOAD_ODD;
            S_LOAD_ODD: begin
                o_odd_ready = 1'b1;
                if (w_odd_acc && i_odd_last) w_next_state = S_WAIT_EVEN;
            end
            S_WAIT_EVEN: begin
                o_even_ready = 1'b1;
                if (w_even_acc) w_next_state = S_LOAD_CAND;
            end
            S_LOAD_CAND: w_next_state = S_RUN;
            S_RUN: begin
                if (w_mismatch) begin
                    w_next_state = S_NEXT;
                end else if (w_last_bit) begin
`ifdef CRYPTO1_MULTI_MATCH_EN
                    w_next_state = S_NEXT;
`else
                    w_next_state = S_FINISH;
`endif
                end
            end
            S_NEXT: begin
                if (w_more)           w_next_state = S_LOAD_CAND;
                else if (r_even_last) w_next_state = S_FINISH;
                else                  w_next_state = S_WAIT_EVEN;
            end
            S_FINISH:    w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Odd buffer is plain storage; entries beyond wr_cnt are never read.
    always_ff @(posedge i_clk) begin
        if (w_odd_acc && !w_full) r_buf[r_wr_cnt[AW-1:0]] <= i_odd_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ks        <= '0;
            r_wr_cnt    <= '0;
            r_rd_idx    <= '0;
            r_even_in   <= '0;
            r_even_last <= 1'b0;
            r_odd       <= '0;
            r_even      <= '0;
            r_bit_idx   <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_ks       <= i_bitstream;
                        r_wr_cnt   <= '0;
                        r_done     <= 1'b0;
                        r_found    <= 1'b0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD_ODD: begin
                    if (w_odd_acc) begin
                        if (w_full) r_overflow <= 1'b1;
                        else        r_wr_cnt   <= r_wr_cnt + CW'(1);
                    end
                end
                S_WAIT_EVEN: begin
                    if (w_even_acc) begin
                        r_even_in   <= i_even_data;
                        r_even_last <= i_even_last;
                        r_rd_idx    <= '0;
                    end
                end
                S_LOAD_CAND: begin
                    r_odd     <= w_cand_odd;
                    r_even    <= r_even_in;
                    r_bit_idx <= '0;
                end
                S_RUN: begin
                    if (!w_mismatch) begin
                        // shift the even half, then swap roles of the halves
                        r_odd     <= w_even_shift;
                        r_even    <= r_odd;
                        r_bit_idx <= r_bit_idx + BW'(1);
                        if (w_last_bit) begin
                            r_key       <= w_key;
                            r_key_valid <= 1'b1;
                            r_found     <= 1'b1;
                        end
                    end
                end
                S_NEXT: begin
                    if (w_more) r_rd_idx <= r_rd_idx + AW'(1);
                end
                S_FINISH: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_key       = r_key;
    assign o_key_valid = r_key_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_found     = r_found;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_crypto1_search_engine.sv
// tb_crypto1_search_engine
//
// Directed bench for crypto1_search_engine (ODD_DEPTH=4, KS_BITS=48). The
// expected keystreams and keys come from a crapto1-style reference function.
// Multi-match expectations follow CRYPTO1_MULTI_MATCH_EN when it is defined.
module tb_crypto1_search_engine;

    localparam int KS    = 48;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [47:0] bitstream = '0;
    logic        oddValid = 1'b0;
    logic [23:0] oddData = '0;
    logic        oddLast = 1'b0;
    logic        oddReady;
    logic        evenValid = 1'b0;
    logic [23:0] evenData = '0;
    logic        evenLast = 1'b0;
    logic        evenReady;
    logic [47:0] key;
    logic        keyValid, busy, done, found, overflow;

    int          checkCount = 0;
    int          errCount = 0;
    int          kvCount = 0;
    int          evenHs = 0;
    logic [47:0] firstKey = '0;
    logic [47:0] lastKey = '0;
    logic [23:0] oddList [8];
    logic [23:0] evenList [4];

    crypto1_search_engine #(.KS_BITS(KS), .ODD_DEPTH(DEPTH), .SUBKEY_W(24)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_bitstream(bitstream),
        .i_odd_valid(oddValid), .i_odd_data(oddData), .i_odd_last(oddLast),
        .o_odd_ready(oddReady),
        .i_even_valid(evenValid), .i_even_data(evenData), .i_even_last(evenLast),
        .o_even_ready(evenReady),
        .o_key(key), .o_key_valid(keyValid), .o_busy(busy), .o_done(done),
        .o_found(found), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge, so the falling edge sees the
    // values that the next rising edge will act on.
    always @(negedge clk) begin
        if (keyValid) begin
            if (kvCount == 0) firstKey = key;
            lastKey = key;
            kvCount++;
        end
        if (evenReady && evenValid) evenHs++;
    end

    function automatic logic [47:0] modelKs(input logic [23:0] ev, input logic [23:0] od);
        logic [31:0] e, o, t, f, g;
        logic [47:0] r;
        e = {8'h0, ev};
        o = {8'h0, od};
        r = '0;
        for (int k = 0; k < KS; k++) begin
            f = ((32'hF22C0 >> (o & 32'hF)) & 32'd16)
              | ((32'h6C9C0 >> ((o >> 4) & 32'hF)) & 32'd8)
              | ((32'h3C8B0 >> ((o >> 8) & 32'hF)) & 32'd4)
              | ((32'h1E458 >> ((o >> 12) & 32'hF)) & 32'd2)
              | ((32'h0D938 >> ((o >> 16) & 32'hF)) & 32'd1);
            g = 32'hEC57E80A >> f;
            r[k] = g[0];
            t = (o & 32'h29CE5C) ^ (e & 32'h870804);
            e = ((e << 1) | {31'h0, ^t}) & 32'hFFFFFF;
            t = o;
            o = e;
            e = t;
        end
        return r;
    endfunction

    function automatic logic [47:0] modelKey(input logic [23:0] ev, input logic [23:0] od);
        logic [47:0] k;
        k = '0;
        for (int i = 0; i < 24; i++) begin
            k[2*i]   = ev[i];
            k[2*i+1] = od[i];
        end
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendOdd(input logic [23:0] d, input logic last, input bit stall);
        bit seen;
        int n;
        if (stall) repeat ($urandom_range(0, 3)) tick();
        oddValid = 1'b1; oddData = d; oddLast = last;
        seen = 1'b0; n = 0;
        while (!seen && n < 100) begin
            seen = oddReady;
            tick();
            n++;
        end
        oddValid = 1'b0; oddLast = 1'b0;
        if (!seen) begin
            checkCount++; errCount++;
            $display("[TB] FAIL odd_handshake: no ready within %0d cycles, required accept", n);
        end
    endtask

    task automatic sendEven(input logic [23:0] d, input logic last, input bit stall, output bit accepted);
        int n;
        if (stall) repeat ($urandom_range(0, 3)) tick();
        evenValid = 1'b1; evenData = d; evenLast = last;
        accepted = 1'b0; n = 0;
        while (!accepted && n < 200) begin
            if (done) break;
            accepted = evenReady;
            tick();
            n++;
        end
        evenValid = 1'b0; evenLast = 1'b0;
        if (!accepted && !done) begin
            checkCount++; errCount++;
            $display("[TB] FAIL even_handshake: no ready within %0d cycles, required accept", n);
        end
    endtask

    task automatic applyStimulus(input logic [47:0] bs, input int nOdd, input int nEven, input bit stall);
        bit acc;
        int n;
        kvCount = 0; evenHs = 0;
        bitstream = bs; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < nOdd; i++) begin
            sendOdd(oddList[i], (i == nOdd - 1), stall);
            if (stall && i == 0) begin
                bitstream = '0; start = 1'b1;
                tick();
                start = 1'b0; bitstream = bs;
            end
        end
        for (int i = 0; i < nEven; i++) begin
            sendEven(evenList[i], (i == nEven - 1), stall, acc);
            if (!acc) break;
        end
        n = 0;
        while (!done && n < 2000) begin
            tick();
            n++;
        end
        if (!done) begin
            checkCount++; errCount++;
            $display("[TB] FAIL search_timeout: done=%0b after %0d cycles, required 1", done, n);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checkCount++; if (busy !== 1'b0)      begin errCount++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        checkCount++; if (done !== 1'b0)      begin errCount++; $display("[TB] FAIL reset_done: got %0b want 0", done); end
        checkCount++; if (found !== 1'b0)     begin errCount++; $display("[TB] FAIL reset_found: got %0b want 0", found); end
        checkCount++; if (overflow !== 1'b0)  begin errCount++; $display("[TB] FAIL reset_overflow: got %0b want 0", overflow); end
        checkCount++; if (keyValid !== 1'b0)  begin errCount++; $display("[TB] FAIL reset_key_valid: got %0b want 0", keyValid); end
        checkCount++; if (key !== 48'h0)      begin errCount++; $display("[TB] FAIL reset_key: got %h want 0", key); end
        checkCount++; if (oddReady !== 1'b0)  begin errCount++; $display("[TB] FAIL reset_odd_ready: got %0b want 0", oddReady); end
        checkCount++; if (evenReady !== 1'b0) begin errCount++; $display("[TB] FAIL reset_even_ready: got %0b want 0", evenReady); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_match();
        logic [47:0] want;
        oddList[0] = 24'h000001; oddList[1] = 24'h123456; oddList[2] = 24'hABCDEF;
        evenList[0] = 24'h555555;
        want = modelKey(24'h555555, 24'h123456);
        applyStimulus(modelKs(24'h555555, 24'h123456), 3, 1, 1'b0);
        checkCount++; if (kvCount != 1)      begin errCount++; $display("[TB] FAIL match_count: got %0d want 1", kvCount); end
        checkCount++; if (lastKey !== want)  begin errCount++; $display("[TB] FAIL match_key: got %h want %h", lastKey, want); end
        checkCount++; if (found !== 1'b1)    begin errCount++; $display("[TB] FAIL match_found: got %0b want 1", found); end
        checkCount++; if (done !== 1'b1)     begin errCount++; $display("[TB] FAIL match_done: got %0b want 1", done); end
        checkCount++; if (busy !== 1'b0)     begin errCount++; $display("[TB] FAIL match_busy: got %0b want 0", busy); end
        checkCount++; if (overflow !== 1'b0) begin errCount++; $display("[TB] FAIL match_overflow: got %0b want 0", overflow); end
        checkCount++; if (evenHs != 1)       begin errCount++; $display("[TB] FAIL match_even_hs: got %0d want 1", evenHs); end
    endtask

    task automatic test_no_match();
        applyStimulus(48'h0, 3, 1, 1'b0);
        checkCount++; if (kvCount != 0)   begin errCount++; $display("[TB] FAIL nomatch_count: got %0d want 0", kvCount); end
        checkCount++; if (found !== 1'b0) begin errCount++; $display("[TB] FAIL nomatch_found: got %0b want 0", found); end
        checkCount++; if (done !== 1'b1)  begin errCount++; $display("[TB] FAIL nomatch_done: got %0b want 1", done); end
        checkCount++; if (evenHs != 1)    begin errCount++; $display("[TB] FAIL nomatch_even_hs: got %0d want 1", evenHs); end
    endtask

    task automatic test_overflow();
        logic [47:0] bs, want;
        bs = modelKs(24'h555555, 24'h123456);
        want = modelKey(24'h555555, 24'h123456);
        evenList[0] = 24'h555555;
        // matching odd half at the last kept entry (index 3)
        oddList[0] = 24'h000001; oddList[1] = 24'h000002; oddList[2] = 24'h000003;
        oddList[3] = 24'h123456; oddList[4] = 24'hABCDEF; oddList[5] = 24'h654321;
        applyStimulus(bs, 6, 1, 1'b0);
        checkCount++; if (overflow !== 1'b1) begin errCount++; $display("[TB] FAIL ovf_a_flag: got %0b want 1", overflow); end
        checkCount++; if (kvCount != 1)      begin errCount++; $display("[TB] FAIL ovf_a_count: got %0d want 1", kvCount); end
        checkCount++; if (lastKey !== want)  begin errCount++; $display("[TB] FAIL ovf_a_key: got %h want %h", lastKey, want); end
        // matching odd half only in a dropped entry (index 4)
        oddList[3] = 24'hABCDEF; oddList[4] = 24'h123456;
        applyStimulus(bs, 6, 1, 1'b0);
        checkCount++; if (overflow !== 1'b1) begin errCount++; $display("[TB] FAIL ovf_b_flag: got %0b want 1", overflow); end
        checkCount++; if (found !== 1'b0)    begin errCount++; $display("[TB] FAIL ovf_b_found: got %0b want 0", found); end
        checkCount++; if (kvCount != 0)      begin errCount++; $display("[TB] FAIL ovf_b_count: got %0d want 0", kvCount); end
        checkCount++; if (done !== 1'b1)     begin errCount++; $display("[TB] FAIL ovf_b_done: got %0b want 1", done); end
    endtask

    task automatic test_multi_match();
        logic [47:0] want;
        int wantCount, wantHs;
`ifdef CRYPTO1_MULTI_MATCH_EN
        wantCount = 2; wantHs = 2;
`else
        wantCount = 1; wantHs = 1;
`endif
        want = modelKey(24'h555555, 24'h123456);
        oddList[0] = 24'h123456; oddList[1] = 24'h000001; oddList[2] = 24'h123456;
        evenList[0] = 24'h555555; evenList[1] = 24'h111111;
        applyStimulus(modelKs(24'h555555, 24'h123456), 3, 2, 1'b0);
        checkCount++; if (kvCount != wantCount) begin errCount++; $display("[TB] FAIL multi_count: got %0d want %0d", kvCount, wantCount); end
        checkCount++; if (firstKey !== want)     begin errCount++; $display("[TB] FAIL multi_first_key: got %h want %h", firstKey, want); end
        checkCount++; if (lastKey !== want)      begin errCount++; $display("[TB] FAIL multi_last_key: got %h want %h", lastKey, want); end
        checkCount++; if (evenHs != wantHs)      begin errCount++; $display("[TB] FAIL multi_even_hs: got %0d want %0d", evenHs, wantHs); end
        checkCount++; if (overflow !== 1'b0)     begin errCount++; $display("[TB] FAIL multi_overflow_clear: got %0b want 0", overflow); end
        checkCount++; if (done !== 1'b1)         begin errCount++; $display("[TB] FAIL multi_done: got %0b want 1", done); end
    endtask

    task automatic test_stall();
        logic [47:0] want;
        want = modelKey(24'h555555, 24'h123456);
        oddList[0] = 24'h000001; oddList[1] = 24'h123456; oddList[2] = 24'hABCDEF;
        evenList[0] = 24'h555555;
        applyStimulus(modelKs(24'h555555, 24'h123456), 3, 1, 1'b1);
        checkCount++; if (kvCount != 1)     begin errCount++; $display("[TB] FAIL stall_count: got %0d want 1", kvCount); end
        checkCount++; if (lastKey !== want) begin errCount++; $display("[TB] FAIL stall_key: got %h want %h", lastKey, want); end
        checkCount++; if (found !== 1'b1)   begin errCount++; $display("[TB] FAIL stall_found: got %0b want 1", found); end
        checkCount++; if (evenHs != 1)      begin errCount++; $display("[TB] FAIL stall_even_hs: got %0d want 1", evenHs); end
    endtask

    task automatic test_reset_mid_run();
        bit acc;
        oddList[0] = 24'h123456;
        evenList[0] = 24'h555555;
        bitstream = modelKs(24'h555555, 24'h123456);
        start = 1'b1;
        tick();
        start = 1'b0;
        sendOdd(24'h123456, 1'b1, 1'b0);
        sendEven(24'h555555, 1'b1, 1'b0, acc);
        repeat (6) tick();
        rst = 1'b1;
        #2;
        kvCount = 0;
        checkCount++; if (busy !== 1'b0)     begin errCount++; $display("[TB] FAIL midrst_busy: got %0b want 0", busy); end
        checkCount++; if (key !== 48'h0)     begin errCount++; $display("[TB] FAIL midrst_key: got %h want 0", key); end
        checkCount++; if (found !== 1'b0)    begin errCount++; $display("[TB] FAIL midrst_found: got %0b want 0", found); end
        checkCount++; if (keyValid !== 1'b0) begin errCount++; $display("[TB] FAIL midrst_key_valid: got %0b want 0", keyValid); end
        tick();
        rst = 1'b0;
        repeat (60) tick();
        checkCount++; if (kvCount != 0)   begin errCount++; $display("[TB] FAIL midrst_no_pulse: got %0d want 0", kvCount); end
        checkCount++; if (done !== 1'b0)  begin errCount++; $display("[TB] FAIL midrst_done: got %0b want 0", done); end
        applyStimulus(modelKs(24'h555555, 24'h123456), 1, 1, 1'b0);
        checkCount++; if (kvCount != 1)   begin errCount++; $display("[TB] FAIL midrst_rerun_count: got %0d want 1", kvCount); end
        checkCount++; if (found !== 1'b1) begin errCount++; $display("[TB] FAIL midrst_rerun_found: got %0b want 1", found); end
    endtask

    initial begin
        $display("[TB] crypto1_search_engine bench start");
        test_reset();
        test_match();
        test_no_match();
        test_overflow();
        test_multi_match();
        test_stall();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
        $finish;
    end

endmodule
